glitch_filter_monitor: RTL and testbench

- Downstream stage for the combinational hazard network output F, which has a known static-1 hazard: a 2 ns drop to 0 between 7 ns and 9 ns after `a` falls 1→0.
- Synchronises F into the clk domain and qualifies each level change over STABLE_CYCLES consecutive samples before passing it on.
- Emits a clean level plus one-cycle edge pulses, and counts rejected pulses (glitches) for observability.

---
 rtl/glitch_filter_monitor.sv | 160 ++++++++++++++++
 tb/tb_glitch_filter_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_filter_monitor.sv
// rtl/glitch_filter_monitor.sv - synchronise, qualify and glitch-count the hazard network output (option: GLITCH_WIDTH_EN)
module glitch_filter_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_in,
    input  logic             clear,
    output logic             f_clean,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] glitch_cnt,
`ifdef GLITCH_WIDTH_EN
    output logic [CNT_W-1:0] max_glitch_w,
`endif
    output logic             glitch_flag
);

    localparam int QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [QW-1:0]          qcnt_q, qcnt_d;
    logic                   commit_rise, commit_fall, glitch_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], f_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // f_clean is decoded from state so an asynchronous reset clears it at once
    assign f_clean = (state_q == STABLE_HI) || (state_q == QUAL_LO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            qcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        commit_rise = 1'b0;
        commit_fall = 1'b0;
        glitch_ev   = 1'b0;
        case (state_q)
            STABLE_LO: if (s) begin
                if (STABLE_CYCLES == 1) begin
                    state_d     = STABLE_HI;
                    commit_rise = 1'b1;
                end else begin
                    state_d = QUAL_HI;
                    qcnt_d  = QW'(1);
                end
            end
            QUAL_HI: begin
                if (s) begin
                    if (qcnt_q == Q_LAST) begin
                        state_d     = STABLE_HI;
                        qcnt_d      = '0;
                        commit_rise = 1'b1;
                    end else begin
                        qcnt_d = qcnt_q + QW'(1);
                    end
                end else begin
                    state_d   = STABLE_LO;
                    qcnt_d    = '0;
                    glitch_ev = 1'b1;
                end
            end
            STABLE_HI: if (!s) begin
                if (STABLE_CYCLES == 1) begin
                    state_d     = STABLE_LO;
                    commit_fall = 1'b1;
                end else begin
                    state_d = QUAL_LO;
                    qcnt_d  = QW'(1);
                end
            end
            QUAL_LO: begin
                if (!s) begin
                    if (qcnt_q == Q_LAST) begin
                        state_d     = STABLE_LO;
                        qcnt_d      = '0;
                        commit_fall = 1'b1;
                    end else begin
                        qcnt_d = qcnt_q + QW'(1);
                    end
                end else begin
                    state_d   = STABLE_HI;
                    qcnt_d    = '0;
                    glitch_ev = 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                qcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= commit_rise;
            fall_pulse <= commit_fall;
        end
    end

    // clear wins over a simultaneous abort; that glitch is intentionally dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt  <= '0;
            glitch_flag <= 1'b0;
        end else if (clear) begin
            glitch_cnt  <= '0;
            glitch_flag <= 1'b0;
        end else if (glitch_ev) begin
            if (glitch_cnt != {CNT_W{1'b1}}) begin
                glitch_cnt <= glitch_cnt + CNT_W'(1);
            end
            glitch_flag <= 1'b1;
        end
    end

`ifdef GLITCH_WIDTH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_glitch_w <= '0;
        end else if (clear) begin
            max_glitch_w <= '0;
        end else if (glitch_ev && (32'(qcnt_q) > 32'(max_glitch_w))) begin
            max_glitch_w <= CNT_W'(qcnt_q);
        end
    end
`endif

endmodule

// File: tb/tb_glitch_filter_monitor.sv
// tb/tb_glitch_filter_monitor.sv - directed plus random bench with a sample-history reference model
module tb_glitch_filter_monitor;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int CW     = 8;

    logic          clk;
    logic          rst_n;
    logic          f_in;
    logic          clear;
    logic          f_clean;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] glitch_cnt;
    logic          glitch_flag;
`ifdef GLITCH_WIDTH_EN
    logic [CW-1:0] max_glitch_w;
`endif

    glitch_filter_monitor #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_in        (f_in),
        .clear       (clear),
        .f_clean     (f_clean),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .glitch_cnt  (glitch_cnt),
`ifdef GLITCH_WIDTH_EN
        .max_glitch_w(max_glitch_w),
`endif
        .glitch_flag (glitch_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: history of f_in as sampled on each edge since reset
    bit samp [0:16383];
    int k;
    bit m_clean, m_rise, m_fall, m_flag;
    int m_cnt, m_maxw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; m_clean = 0; m_rise = 0; m_fall = 0; m_flag = 0; m_cnt = 0; m_maxw = 0;
    endtask

    // value the qualifier sees at edge j: f_in sampled SYNC edges earlier
    function automatic bit seen_at(input int j);
        return (j - SYNC >= 1) ? samp[j-SYNC] : 1'b0;
    endfunction

    function automatic int run_back(input int j);
        int n = 0;
        for (int i = j; i >= 1; i--) begin
            if (seen_at(i) == m_clean) break;
            n++;
        end
        return n;
    endfunction

    function automatic bit glitch_next();
        return (seen_at(k + 1) == m_clean) && (k >= 1) && (seen_at(k) != m_clean);
    endfunction

    task automatic model_edge(input bit smp, input bit clr);
        bit g;
        int w;
        k++;
        samp[k] = smp;
        m_rise = 0; m_fall = 0; g = 0; w = 0;
        if (seen_at(k) != m_clean) begin
            if (run_back(k) >= STABLE) begin
                m_clean = ~m_clean;
                if (m_clean) m_rise = 1; else m_fall = 1;
            end
        end else if (seen_at(k - 1) != m_clean && k >= 2) begin
            g = 1;
            w = run_back(k - 1);
        end
        if (clr) begin
            m_cnt = 0; m_flag = 0; m_maxw = 0;
        end else if (g) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            m_flag = 1;
            if (w > m_maxw) m_maxw = w;
        end
    endtask

    task automatic check_all();
        chk("f_clean", f_clean, m_clean);
        chk("rise_pulse", rise_pulse, m_rise);
        chk("fall_pulse", fall_pulse, m_fall);
        chk("glitch_cnt", glitch_cnt, m_cnt);
        chk("glitch_flag", glitch_flag, m_flag);
`ifdef GLITCH_WIDTH_EN
        chk("max_glitch_w", max_glitch_w, m_maxw);
`endif
        chk("pulse_excl", rise_pulse & fall_pulse, 1'b0);
    endtask

    task automatic edge_check(input bit clr);
        clear = clr;
        @(posedge clk);
        model_edge(f_in, clr);
        #1;
        check_all();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        int pulses;
        int hit;
        bit lvl;
        int len;

        // reset with f_in high, then release and expect rise on edge 6
        rst_n = 0; f_in = 1; clear = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            edge_check(0);
            if (f_clean && first == 0) first = i;
        end
        chk("rise_edge", first, 6);

        // 2-unit drop entirely between edges: never sampled
        #2 f_in = 0;
        #2 f_in = 1;
        for (int i = 0; i < 8; i++) edge_check(0);
        chk("hazard_between_cnt", glitch_cnt, 0);

        // 2-unit drop straddling an edge: sampled once, rejected and counted
        #8 f_in = 0;
        @(posedge clk);
        model_edge(f_in, 0);
        #1 f_in = 1;
        check_all();
        for (int i = 0; i < 8; i++) edge_check(0);
        chk("hazard_straddle_cnt", glitch_cnt, 1);
        chk("hazard_straddle_flag", glitch_flag, 1);

        // three low cycles: one short of committing
        f_in = 0;
        for (int i = 0; i < 3; i++) edge_check(0);
        f_in = 1;
        for (int i = 0; i < 8; i++) edge_check(0);
        chk("b3_cnt", glitch_cnt, 2);
        chk("b3_clean", f_clean, 1);

        // four low cycles: commits a fall six edges after the drop
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            f_in = (i <= 4) ? 1'b0 : 1'b1;
            edge_check(0);
            if (!f_clean && first == 0) first = i;
        end
        chk("fall_edge", first, 6);
        for (int i = 0; i < 10; i++) edge_check(0);
        chk("b4_cnt", glitch_cnt, 2);

        // clear lands on the abort edge of a two-cycle pulse
        hit = 0;
        for (int i = 0; i < 12; i++) begin
            f_in = (i < 2) ? 1'b0 : 1'b1;
            if (glitch_next()) hit++;
            edge_check(glitch_next());
        end
        chk("clr_hit", hit, 1);
        chk("clr_cnt", glitch_cnt, 0);
        chk("clr_flag", glitch_flag, 0);
        chk("clr_clean", f_clean, 1);

        // saturation: 300 rejected two-cycle pulses
        for (int p = 0; p < 300; p++) begin
            f_in = 0;
            repeat (2) edge_check(0);
            f_in = 1;
            repeat (10) edge_check(0);
        end
        chk("sat_cnt", glitch_cnt, 255);
        chk("sat_flag", glitch_flag, 1);
`ifdef GLITCH_WIDTH_EN
        chk("sat_maxw", max_glitch_w, 2);
`endif

        // random runs of levels with occasional clears
        for (int i = 0; i < 300; i++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            f_in = lvl;
            for (int j = 0; j < len; j++) edge_check($urandom_range(0, 31) == 0);
        end

        // asynchronous reset while qualifying a fall
        f_in = 1;
        for (int i = 0; i < 12; i++) edge_check(0);
        f_in = 0;
        for (int i = 0; i < 4; i++) edge_check(0);
        chk("pre_rst_clean", f_clean, 1);
        #3 rst_n = 0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #4 rst_n = 1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            edge_check(0);
            pulses += int'(rise_pulse) + int'(fall_pulse);
        end
        chk("post_rst_pulses", pulses, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
